reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Next-generation integer register file for the BearCore-V pipeline.
- Parametrised in data width, register count and number of read/write ports.
- Adds a per-register scoreboard of pending writes, so issue logic can stall multi-cycle ops (loads, mul/div).
- Adds a sequential soft-clear sweep FSM, used by debug or hart-restart, that re-initialises the file without asserting rst_n.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=4)
AW, 5, address width; must equal log2(NREG)
NRD, 2, number of read ports
NWR, 2, number of write ports
SP_IDX, 2, index of the stack-pointer register
SP_INIT, 32'h00008000, reset/clear value of register SP_IDX

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
raddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rdata  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
rbusy  out  NRD  scoreboard pending bit for each raddr
wen  in  NWR  write enables
waddr  in  NWR*AW  write addresses, packed per port
wdata  in  NWR*XLEN  write data, packed per port
iss_valid  in  1  issue strobe; marks iss_addr pending
iss_addr  in  AW  destination register being issued
init_req  in  1  single-cycle soft-clear request
ready  out  1  1 = IDLE, accepting writes and issues

Behaviour:
- Storage: NREG x XLEN flops.
- Register 0 always reads 0. Writes to 0 are discarded. Its pending bit never sets.
- Async reset, applied immediately:
  - all registers 0, except register SP_IDX = SP_INIT
  - all pending bits 0
  - FSM = IDLE, ready = 1
  - sweep counter = 1
- Reads are combinational, zero latency.
  - rdata[k] = regs[raddr[k]], subject to bypass (see Optional Feature).
  - rbusy[k] = pend[raddr[k]] registered value, not bypassed.
- Writes occur at clk rising edge when wen[j] = 1, waddr[j] != 0 and FSM = IDLE.
  - If two ports write the same address in one cycle, the higher port index wins.
- Scoreboard, per register r != 0, at clk edge in IDLE:
  - set when iss_valid and iss_addr == r
  - clear when any enabled write port targets r
  - simultaneous set and clear: set wins (younger issue still outstanding)
  - pending bit already set and iss_valid again to the same r: stays set; no error flag
- FSM IDLE:
  - init_req = 1 -> INIT, ready drops to 0 next cycle, counter = 1
  - wen and iss_valid in the same cycle as init_req are still honoured
- FSM INIT:
  - each cycle regs[cnt] <= (cnt == SP_IDX) ? SP_INIT : 0, pend[cnt] <= 0, cnt++
  - after cnt == NREG-1 is cleared -> IDLE, ready = 1 next cycle
  - total time in INIT: NREG-1 cycles (31 at default)
  - wen, iss_valid and init_req are ignored while in INIT
  - reads stay live and return current array contents (partially swept)
- rst_n asserted mid-sweep: immediate full reset, FSM = IDLE.
- Counter wrap: cnt is AW bits. After the final clear it is reloaded to 1, never wraps to 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first internal forwarding.
  - If FSM = IDLE and any wen[j] with waddr[j] == raddr[k] != 0, then rdata[k] = wdata[j] of the highest such j.
  - Same-cycle write-then-read returns the new value.
- Not defined: rdata is array contents only. A write becomes visible on the cycle after the clk edge, and the hazard unit must forward or stall.
- rbusy is unaffected in both modes.

Test Plan:
- Reset release, read x2 and x5 -> rdata = 0x00008000 and 0; ready = 1; rbusy = 0; write x0 = 0xDEADBEEF then read x0 -> 0.
- wen = 2'b11, both waddr = 7, wdata0 = 0x11, wdata1 = 0x22 -> x7 = 0x22 next cycle. With REGFILE_BYPASS_EN, same-cycle read of x7 = 0x22; without it, same-cycle read returns the old value 0.
- iss_valid with iss_addr = 9 -> rbusy for x9 = 1 next cycle. Later, in the same cycle: port0 writes x9 = 0x55 and iss_valid with iss_addr = 9 -> x9 = 0x55 and rbusy stays 1. Write x9 again with no issue -> rbusy = 0.
- Load x3 = 0xA5A5, x2 = 0x1234, set pend[4], then pulse init_req -> ready = 0 for exactly 31 cycles. Writes during INIT are dropped. At exit: x3 = 0, x2 = 0x00008000, pend all 0.
- Assert rst_n at sweep cycle 10 with x20 = 0xCAFE not yet swept -> x20 = 0 immediately, ready = 1, FSM IDLE.
- NRD = 4, NWR = 1, NREG = 16, AW = 4 build: concurrent reads of x0, x1, x15, x15 after writing x15 = 0x77 -> rdata = {0x77, 0x77, x1, 0}.

Source files
------------

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with pending-write scoreboard and a soft-clear sweep FSM.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding on the read ports.
module reg_file_sb #(
  parameter int unsigned     XLEN    = 32,
  parameter int unsigned     NREG    = 32,
  parameter int unsigned     AW      = 5,
  parameter int unsigned     NRD     = 2,
  parameter int unsigned     NWR     = 2,
  parameter int unsigned     SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = XLEN'(32'h0000_8000)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                init_req,
  output logic                ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] SP_ADDR  = AW'(SP_IDX);

  typedef enum logic [0:0] {S_IDLE, S_INIT} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [AW-1:0]   cnt;
  logic            sweep_last_c;

  assign sweep_last_c = (cnt == LAST_IDX);
  assign ready        = (state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (init_req)     state_nxt = S_INIT;
      S_INIT:  if (sweep_last_c) state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Storage, scoreboard and sweep counter; register 0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++)
        regs[r] <= (r == SP_IDX) ? SP_INIT : '0;
      pend <= '0;
      cnt  <= AW'(1);
    end else if (state == S_INIT) begin
      regs[cnt] <= (cnt == SP_ADDR) ? SP_INIT : '0;
      pend[cnt] <= 1'b0;
      cnt       <= sweep_last_c ? AW'(1) : cnt + AW'(1);
    end else begin
      // Ascending port order: the highest-indexed writer wins
      for (int j = 0; j < int'(NWR); j++) begin
        if (wen[j] && (waddr[j*AW +: AW] != '0)) begin
          regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
          pend[waddr[j*AW +: AW]] <= 1'b0;
        end
      end
      // A younger issue to the same register keeps it pending
      if (iss_valid && (iss_addr != '0))
        pend[iss_addr] <= 1'b1;
      cnt <= AW'(1);
    end
  end

  // Combinational read ports
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      rdata[k*XLEN +: XLEN] = regs[raddr[k*AW +: AW]];
      rbusy[k]              = pend[raddr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < int'(NWR); j++) begin
        if ((state == S_IDLE) && wen[j] && (raddr[k*AW +: AW] != '0) &&
            (waddr[j*AW +: AW] == raddr[k*AW +: AW]))
          rdata[k*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
      end
`else
      rdata[k*XLEN +: XLEN] = rdata[k*XLEN +: XLEN];
`endif
    end
  end

endmodule
